instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage of the RV32I pipeline: owns the program counter and drives InstructionAddress into the
//  combinational InstructionMemory. Captures the returned ReadInstruction and its PC into the IF/ID
//  pipeline register for the decode stage. Handles stall, flush and branch/jump redirect from later
//  stages, and traps misaligned or out-of-range fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  MEM_SIZE   1024           instruction memory size in bytes; legal fetch PC range 0..MEM_SIZE-4
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) inserted into IF/ID
// PORTS
//  clk               in   1   clock, all state updates on rising edge
//  reset             in   1   asynchronous, active-high reset
//  Stall             in   1   hazard unit: hold PC and IF/ID contents
//  Flush             in   1   replace IF/ID contents with a bubble
//  BranchTaken       in   1   redirect request from EX
//  BranchTarget      in   32  redirect PC, valid when BranchTaken=1
//  ReadInstruction   in   32  instruction word from InstructionMemory (same-cycle, combinational)
//  InstructionAddress out 32  current PC to InstructionMemory (= PC register, no logic after the flop)
//  IfIdInstruction   out 32  registered instruction for decode
//  IfIdPC            out 32  PC of IfIdInstruction
//  IfIdPCPlus4       out 32  IfIdPC + 4, for JAL/JALR link
//  IfIdValid         out 1   IF/ID holds a real instruction (0 = bubble)
//  FetchFault        out 1   sticky fault flag
//  FaultPC           out 32  offending address captured on fault entry
//  FetchCount        out 32  number of instructions written into IF/ID as valid
// BEHAVIOUR
//  Reset (async): PC=RESET_PC, IfIdInstruction=NOP_INSTR, IfIdPC=0, IfIdPCPlus4=0, IfIdValid=0,
//   FetchFault=0, FaultPC=0, FetchCount=0, state=RUN. First valid IF/ID appears one edge after
//   reset deasserts.
//  Latency: the instruction at PC p is in IF/ID one edge after InstructionAddress=p.
//  State RUN, per edge, in priority order:
//   1 BranchTaken & BranchTarget[1:0]!=0 -> FAULT; FaultPC=BranchTarget; PC holds; IF/ID bubble.
//   2 BranchTaken (aligned) -> PC=BranchTarget; IF/ID bubble (the wrong-path instr is dropped);
//     Stall is ignored.
//   3 PC > MEM_SIZE-4 -> FAULT; FaultPC=PC; PC holds; IF/ID bubble.
//   4 Stall -> PC holds; IF/ID holds, unless Flush=1 -> IF/ID bubble.
//   5 Flush -> PC=PC+4; IF/ID bubble.
//   6 else -> PC=PC+4; IF/ID={ReadInstruction, PC, PC+4}; IfIdValid=1; FetchCount+=1.
//  Bubble = IfIdInstruction=NOP_INSTR, IfIdValid=0; IfIdPC/IfIdPCPlus4 keep their old values.
//  State FAULT: FetchFault=1; PC, FaultPC and FetchCount frozen; IF/ID held as bubble; all inputs
//   ignored. Exit only via reset.
//  Arithmetic: PC+4 is modulo 2^32. FetchCount wraps 0xFFFF_FFFF -> 0.
//  Reset mid-operation: immediate return to reset values regardless of state or inputs.
// TESTING
//  T1 reset, RESET_PC=0, no stall -> InstructionAddress 0,4,8,...; IfIdPC lags by 1 cycle; IfIdValid=1
//     from 2nd edge; IfIdInstruction = memory word; FetchCount=3 after 3 valid fetches.
//  T2 Stall=1 for 2 cycles at PC=8 -> PC stays 8, IF/ID holds PC 4 instr; resumes at 12 after release.
//  T3 BranchTaken=1, Target=0x40 while Stall=1 -> next PC=0x40, IfIdValid=0, IfIdInstruction=0x13;
//     the following cycle IfIdPC=0x40.
//  T4 BranchTaken, Target=0x42 -> FetchFault=1, FaultPC=0x42, PC frozen, IfIdValid=0 until reset.
//  T5 MEM_SIZE=64, straight-line run -> fault with FaultPC=0x40, FetchCount=16.
//  T6 Flush=1 & Stall=1 together -> PC holds, IF/ID bubble; async reset asserted mid-run -> all outputs
//     at reset values before the next clock edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the RV32I pipeline.
// Owns the PC, drives the combinational instruction memory, and fills the IF/ID
// register. Handles stall, flush and redirect requests. Misaligned redirects and
// fetches beyond the end of memory lock the unit into FAULT until reset.
//
// state | meaning
// RUN   | normal fetch, priority: bad redirect, redirect, range fault, stall, flush, fetch
// FAULT | sticky trap; PC, FaultPC and FetchCount frozen, IF/ID held as a bubble
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_SIZE  = 1024,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] ReadInstruction,
    output logic [31:0] InstructionAddress,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPC,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic        FetchFault,
    output logic [31:0] FaultPC,
    output logic [31:0] FetchCount
);

    typedef enum logic {RUN, FAULT} state_t;

    // Highest PC from which a full 32-bit word can still be fetched.
    localparam logic [31:0] PC_LIMIT = 32'(MEM_SIZE - 4);

    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] instr_next, ifid_pc_next, ifid_pc_plus4_next;
    logic        valid_next;
    logic [31:0] fault_pc_next, count_next;

    assign pc_plus4           = pc + 32'd4;
    assign InstructionAddress = pc;
    assign FetchFault         = (state == FAULT);

    // State and datapath registers; async reset returns everything to reset values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            pc              <= RESET_PC;
            IfIdInstruction <= NOP_INSTR;
            IfIdPC          <= 32'd0;
            IfIdPCPlus4     <= 32'd0;
            IfIdValid       <= 1'b0;
            FaultPC         <= 32'd0;
            FetchCount      <= 32'd0;
        end else begin
            state           <= state_next;
            pc              <= pc_next;
            IfIdInstruction <= instr_next;
            IfIdPC          <= ifid_pc_next;
            IfIdPCPlus4     <= ifid_pc_plus4_next;
            IfIdValid       <= valid_next;
            FaultPC         <= fault_pc_next;
            FetchCount      <= count_next;
        end
    end

    // Next-state and next-datapath decode; everything holds unless a branch below changes it.
    always_comb begin
        state_next         = state;
        pc_next            = pc;
        instr_next         = IfIdInstruction;
        ifid_pc_next       = IfIdPC;
        ifid_pc_plus4_next = IfIdPCPlus4;
        valid_next         = IfIdValid;
        fault_pc_next      = FaultPC;
        count_next         = FetchCount;

        case (state)
            RUN: begin
                if (BranchTaken && (BranchTarget[1:0] != 2'b00)) begin
                    state_next    = FAULT;
                    fault_pc_next = BranchTarget;
                    instr_next    = NOP_INSTR;
                    valid_next    = 1'b0;
                end else if (BranchTaken) begin
                    // Redirect wins over Stall: the wrong-path word is dropped.
                    pc_next    = BranchTarget;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end else if (pc > PC_LIMIT) begin
                    state_next    = FAULT;
                    fault_pc_next = pc;
                    instr_next    = NOP_INSTR;
                    valid_next    = 1'b0;
                end else if (Stall) begin
                    if (Flush) begin
                        instr_next = NOP_INSTR;
                        valid_next = 1'b0;
                    end
                end else if (Flush) begin
                    pc_next    = pc_plus4;
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end else begin
                    pc_next            = pc_plus4;
                    instr_next         = ReadInstruction;
                    ifid_pc_next       = pc;
                    ifid_pc_plus4_next = pc_plus4;
                    valid_next         = 1'b1;
                    count_next         = FetchCount + 32'd1;
                end
            end
            FAULT: begin
                instr_next = NOP_INSTR;
                valid_next = 1'b0;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a full-size instance for fetch,
// stall, flush, redirect, misalignment and async reset, and a 64-byte instance
// for the end-of-memory fault.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_small = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'd0;

    logic [31:0] read_a, addr_a, instr_a, ifid_pc_a, ifid_pc4_a, fault_pc_a, count_a;
    logic        valid_a, fault_a;
    logic [31:0] read_b, addr_b, instr_b, ifid_pc_b, ifid_pc4_b, fault_pc_b, count_b;
    logic        valid_b, fault_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    assign read_a = mem_word(addr_a);
    assign read_b = mem_word(addr_b);

    instruction_fetch_unit dut_a (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .ReadInstruction(read_a), .InstructionAddress(addr_a),
        .IfIdInstruction(instr_a), .IfIdPC(ifid_pc_a), .IfIdPCPlus4(ifid_pc4_a),
        .IfIdValid(valid_a), .FetchFault(fault_a), .FaultPC(fault_pc_a),
        .FetchCount(count_a)
    );

    instruction_fetch_unit #(.MEM_SIZE(64)) dut_b (
        .clk(clk), .reset(reset_small), .Stall(1'b0), .Flush(1'b0),
        .BranchTaken(1'b0), .BranchTarget(32'd0),
        .ReadInstruction(read_b), .InstructionAddress(addr_b),
        .IfIdInstruction(instr_b), .IfIdPC(ifid_pc_b), .IfIdPCPlus4(ifid_pc4_b),
        .IfIdValid(valid_b), .FetchFault(fault_b), .FaultPC(fault_pc_b),
        .FetchCount(count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling and driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] addr,
                            input logic [31:0] instr, input logic [31:0] ipc,
                            input logic valid, input logic [31:0] cnt);
        check({tag, ".addr"},  addr_a, addr);
        check({tag, ".instr"}, instr_a, instr);
        check({tag, ".ifpc"},  ifid_pc_a, ipc);
        check({tag, ".valid"}, {31'd0, valid_a}, {31'd0, valid});
        check({tag, ".count"}, count_a, cnt);
    endtask

    initial begin
        step();
        // Reset values
        check_if("rst", 32'd0, 32'h13, 32'd0, 1'b0, 32'd0);
        check("rst.pc4", ifid_pc4_a, 32'd0);
        check("rst.fault", {31'd0, fault_a}, 32'd0);
        check("rst.faultpc", fault_pc_a, 32'd0);
        reset = 1'b0;

        // T1 straight-line fetch
        step();
        check_if("t1a", 32'd4, mem_word(0), 32'd0, 1'b1, 32'd1);
        check("t1a.pc4", ifid_pc4_a, 32'd4);
        step();
        check_if("t1b", 32'd8, mem_word(4), 32'd4, 1'b1, 32'd2);

        // T2 stall at PC 8 for two cycles
        Stall = 1'b1;
        step();
        check_if("t2a", 32'd8, mem_word(4), 32'd4, 1'b1, 32'd2);
        step();
        check_if("t2b", 32'd8, mem_word(4), 32'd4, 1'b1, 32'd2);
        Stall = 1'b0;
        step();
        check_if("t2c", 32'd12, mem_word(8), 32'd8, 1'b1, 32'd3);
        check("t2c.pc4", ifid_pc4_a, 32'd12);

        // T3 aligned redirect overrides stall
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h40;
        step();
        check_if("t3a", 32'h40, 32'h13, 32'd8, 1'b0, 32'd3);
        Stall = 1'b0; BranchTaken = 1'b0;
        step();
        check_if("t3b", 32'h44, mem_word(32'h40), 32'h40, 1'b1, 32'd4);

        // T6 flush with stall, then flush alone
        Flush = 1'b1; Stall = 1'b1;
        step();
        check_if("t6a", 32'h44, 32'h13, 32'h40, 1'b0, 32'd4);
        Stall = 1'b0;
        step();
        check_if("t6b", 32'h48, 32'h13, 32'h40, 1'b0, 32'd4);
        Flush = 1'b0;
        step();
        check_if("t6c", 32'h4C, mem_word(32'h48), 32'h48, 1'b1, 32'd5);

        // T6 async reset between edges
        reset = 1'b1;
        #1;
        check_if("arst", 32'd0, 32'h13, 32'd0, 1'b0, 32'd0);
        check("arst.pc4", ifid_pc4_a, 32'd0);
        step();
        reset = 1'b0;
        step();
        check_if("arst2", 32'd4, mem_word(0), 32'd0, 1'b1, 32'd1);

        // T4 misaligned redirect traps
        BranchTaken = 1'b1; BranchTarget = 32'h42;
        step();
        check("t4.fault", {31'd0, fault_a}, 32'd1);
        check("t4.faultpc", fault_pc_a, 32'h42);
        check_if("t4a", 32'd4, 32'h13, 32'd0, 1'b0, 32'd1);
        BranchTarget = 32'h80;
        step();
        BranchTaken = 1'b0; Stall = 1'b0;
        step();
        check_if("t4b", 32'd4, 32'h13, 32'd0, 1'b0, 32'd1);
        check("t4b.faultpc", fault_pc_a, 32'h42);
        check("t4b.fault", {31'd0, fault_a}, 32'd1);
        reset = 1'b1;
        #1;
        check("t4.clear", {31'd0, fault_a}, 32'd0);
        reset = 1'b0;

        // T5 end-of-memory fault on the 64-byte instance
        reset_small = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check("t5.addr", addr_b, 32'h40);
        check("t5.count", count_b, 32'd16);
        check("t5.ifpc", ifid_pc_b, 32'h3C);
        check("t5.pc4", ifid_pc4_b, 32'h40);
        check("t5.instr", instr_b, mem_word(32'h3C));
        check("t5.nofault", {31'd0, fault_b}, 32'd0);
        step();
        check("t5.fault", {31'd0, fault_b}, 32'd1);
        check("t5.faultpc", fault_pc_b, 32'h40);
        check("t5.count2", count_b, 32'd16);
        check("t5.valid", {31'd0, valid_b}, 32'd0);
        step();
        check("t5.addr2", addr_b, 32'h40);
        check("t5.count3", count_b, 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
